decode_stage_pipe: RTL and testbench
====================================

// Module: decode_stage_pipe
// PURPOSE
//  Parametrised RV32I/RV32E instruction-decode stage for the 5-stage pipeline.
//  Holds the register file with write-back bypass, generates the immediate and
//  detects load-use hazards. Results go to EX through a valid/ready ID/EX register.
//  Sits between the fetch stage (IF/ID handshake) and the execute stage.
// PARAMETERS
//  XLEN       32   datapath / register width
//  NUM_REGS   32   architectural registers (32 = RV32I, 16 = RV32E)
//  AW         $clog2(NUM_REGS)  register-address width (derived, do not override)
//  BYPASS_WB  1    1: same-cycle WB write is forwarded to the rs reads
//  HAZARD_EN  1    1: load-use stall logic enabled
// PORTS
//  i_clk         in   1     clock
//  i_rst_n       in   1     asynchronous reset, active low
//  i_if_valid    in   1     IF presents a valid instruction
//  o_id_ready    out  1     ID accepts the instruction this cycle
//  i_instr       in   32    instruction word
//  i_pc          in   XLEN  PC of i_instr
//  i_flush       in   1     kill the ID/EX contents (branch taken / trap)
//  i_wb_wren     in   1     write-back enable
//  i_wb_rd_addr  in   AW    write-back destination
//  i_wb_data     in   XLEN  write-back data
//  i_ex_ready    in   1     EX accepts the ID/EX register
//  o_ex_valid    out  1     ID/EX register holds a valid instruction
//  o_ex_pc       out  XLEN  registered PC
//  o_rs1_data    out  XLEN  registered rs1 operand
//  o_rs2_data    out  XLEN  registered rs2 operand
//  o_imme_value  out  XLEN  registered sign-extended immediate
//  o_rd_addr     out  AW    registered destination
//  o_opcode      out  7     registered opcode
//  o_funct3      out  3     registered funct3
//  o_funct7b5    out  1     registered instr[30]
//  o_illegal     out  1     registered illegal flag (unknown opcode or reg index >= NUM_REGS)
// BEHAVIOUR
//  Reset (async, i_rst_n=0): o_ex_valid=0; every registered output = 0; all registers = 0.
//  Register file: NUM_REGS x XLEN flops with two async reads and one sync write.
//  - x0 always reads 0; writes to x0 are dropped.
//  - BYPASS_WB=1: if i_wb_wren and i_wb_rd_addr==rsN!=0 in the same cycle, rsN reads i_wb_data.
//  Immediate: decoded from opcode and sign-extended to XLEN.
//  - I-type: 0010011, 0000011, 1100111.
//  - S: 0100011.  B: 1100011 (bit0=0).  U: 0110111, 0010111 (low 12 bits = 0).  J: 1101111.
//  - R-type and unknown opcodes: 0.
//  Register indices: instr fields are 5 bits. With NUM_REGS=16, a used rs1/rs2/rd with bit4 set:
//  - o_illegal=1; the index is truncated to AW bits.
//  Handshake: adv = !o_ex_valid | i_ex_ready. A single ID/EX stage gives 1-cycle latency.
//  - hazard (HAZARD_EN): o_ex_valid & o_opcode==0000011 & o_rd_addr!=0, and the instruction
//    in ID uses rs1 or rs2 (per its format) equal to o_rd_addr.
//  - o_id_ready = adv & !hazard (combinational).
//  - Capture when i_if_valid & o_id_ready. If adv without capture: o_ex_valid<=0 (bubble).
//  - !adv: all ID/EX outputs hold stable.
//  i_flush (sync): o_ex_valid<=0 and capture is suppressed that cycle; flush beats capture.
//  - The regfile write still takes place during a flush.
//  Forwarding from EX/MEM is not done here; the EX stage handles it.
// STRUCTURE
//  Shared package riscv_pkg: opcode localparams, imm_type_e enum, XLEN default.
//  Sub-module regfile (NUM_REGS, XLEN, BYPASS_WB). Imm-gen and hazard logic stay inline.
// TESTING
//  1 i_rst_n=0 mid-stream -> o_ex_valid=0 and all outputs 0 at once; o_id_ready=1 after release.
//  2 WB x2=0x00410133 in the same cycle as 0x002101B3 (add x3,x2,x2) ->
//    next cycle: rs1=rs2=0x00410133, imm=0, rd=3.
//  3 WB x0=0xDEADBEEF, then 0x00000033 -> rs1=rs2=0.
//  4 Immediate checks:
//    0xFFF00093 -> imm 0xFFFFFFFF;  0x0020A423 -> 0x00000008;
//    0xFE000EE3 -> 0xFFFFFFFC;      0x123452B7 -> 0x12345000.
//  5 0x0000A283 (lw x5) then 0x00028333 (add x6,x5,x0) ->
//    o_id_ready=0 for 1 cycle, one bubble, then add captured.
//  6 i_ex_ready=0 for 3 cycles -> outputs stable and o_id_ready=0; then i_flush=1 ->
//    o_ex_valid=0 next cycle.
//    With NUM_REGS=16, 0x011000B3 -> o_illegal=1.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 decode definitions: opcodes, immediate formats and the
// per-opcode operand-usage table used by the decode stage.
package riscv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_e;

    typedef struct packed {
        logic      known;
        logic      use_rs1;
        logic      use_rs2;
        logic      use_rd;
        imm_type_e imm_type;
    } fmt_t;

    function automatic fmt_t decode_fmt(input logic [6:0] op);
        fmt_t f;
        f.known    = 1'b0;
        f.use_rs1  = 1'b0;
        f.use_rs2  = 1'b0;
        f.use_rd   = 1'b0;
        f.imm_type = IMM_NONE;
        case (op)
            OP_REG: begin
                f.known = 1'b1; f.use_rs1 = 1'b1; f.use_rs2 = 1'b1; f.use_rd = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_JALR: begin
                f.known = 1'b1; f.use_rs1 = 1'b1; f.use_rd = 1'b1; f.imm_type = IMM_I;
            end
            OP_STORE: begin
                f.known = 1'b1; f.use_rs1 = 1'b1; f.use_rs2 = 1'b1; f.imm_type = IMM_S;
            end
            OP_BRANCH: begin
                f.known = 1'b1; f.use_rs1 = 1'b1; f.use_rs2 = 1'b1; f.imm_type = IMM_B;
            end
            OP_LUI, OP_AUIPC: begin
                f.known = 1'b1; f.use_rd = 1'b1; f.imm_type = IMM_U;
            end
            OP_JAL: begin
                f.known = 1'b1; f.use_rd = 1'b1; f.imm_type = IMM_J;
            end
            default: ;
        endcase
        return f;
    endfunction

    // 32-bit sign-extended immediate; the caller widens it to XLEN.
    function automatic logic [31:0] imm_gen(input logic [31:0] instr, input imm_type_e t);
        logic [31:0] imm;
        imm = '0;
        case (t)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/regfile.sv
// Architectural register file: two asynchronous reads, one synchronous write,
// x0 hard-wired to zero, optional same-cycle write-back forwarding.
module regfile #(
    parameter int  XLEN      = 32,
    parameter int  NUM_REGS  = 32,
    parameter bit  BYPASS_WB = 1'b1,
    localparam int AW        = $clog2(NUM_REGS)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_wren,
    input  logic [AW-1:0]   i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [AW-1:0]   i_raddr1,
    input  logic [AW-1:0]   i_raddr2,
    output logic [XLEN-1:0] o_rdata1,
    output logic [XLEN-1:0] o_rdata2
);

    logic [XLEN-1:0] r_mem [NUM_REGS];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wren && (i_waddr != '0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        o_rdata1 = r_mem[i_raddr1];
        if (i_raddr1 == '0) begin
            o_rdata1 = '0;
        end else if (BYPASS_WB && i_wren && (i_waddr == i_raddr1)) begin
            o_rdata1 = i_wdata;
        end
    end

    always_comb begin
        o_rdata2 = r_mem[i_raddr2];
        if (i_raddr2 == '0) begin
            o_rdata2 = '0;
        end else if (BYPASS_WB && i_wren && (i_waddr == i_raddr2)) begin
            o_rdata2 = i_wdata;
        end
    end

endmodule

// File: rtl/decode_stage_pipe.sv
// RV32I/RV32E instruction decode stage: register read, immediate generation,
// load-use stall and the valid/ready ID/EX pipeline register.
module decode_stage_pipe
    import riscv_pkg::*;
#(
    parameter int  XLEN      = XLEN_DEFAULT,
    parameter int  NUM_REGS  = 32,
    parameter bit  BYPASS_WB = 1'b1,
    parameter bit  HAZARD_EN = 1'b1,
    localparam int AW        = $clog2(NUM_REGS)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_if_valid,
    output logic            o_id_ready,
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_flush,
    input  logic            i_wb_wren,
    input  logic [AW-1:0]   i_wb_rd_addr,
    input  logic [XLEN-1:0] i_wb_data,
    input  logic            i_ex_ready,
    output logic            o_ex_valid,
    output logic [XLEN-1:0] o_ex_pc,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data,
    output logic [XLEN-1:0] o_imme_value,
    output logic [AW-1:0]   o_rd_addr,
    output logic [6:0]      o_opcode,
    output logic [2:0]      o_funct3,
    output logic            o_funct7b5,
    output logic            o_illegal
);

    fmt_t               w_fmt;
    logic [6:0]         w_opcode;
    logic [4:0]         w_rs1_f;
    logic [4:0]         w_rs2_f;
    logic [4:0]         w_rd_f;
    logic [AW-1:0]      w_rs1;
    logic [AW-1:0]      w_rs2;
    logic [AW-1:0]      w_rd;
    logic [XLEN-1:0]    w_rs1_data;
    logic [XLEN-1:0]    w_rs2_data;
    logic signed [31:0] w_imm32;
    logic [XLEN-1:0]    w_imm;
    logic               w_idx_bad;
    logic               w_illegal;
    logic               w_hazard;
    logic               w_adv;
    logic               w_capture;

    logic               r_vld_p1;
    logic [XLEN-1:0]    r_pc_p1;
    logic [XLEN-1:0]    r_rs1_data_p1;
    logic [XLEN-1:0]    r_rs2_data_p1;
    logic [XLEN-1:0]    r_imm_p1;
    logic [AW-1:0]      r_rd_p1;
    logic [6:0]         r_opcode_p1;
    logic [2:0]         r_funct3_p1;
    logic               r_funct7b5_p1;
    logic               r_illegal_p1;

    assign w_opcode = i_instr[6:0];
    assign w_rd_f   = i_instr[11:7];
    assign w_rs1_f  = i_instr[19:15];
    assign w_rs2_f  = i_instr[24:20];
    assign w_rs1    = w_rs1_f[AW-1:0];
    assign w_rs2    = w_rs2_f[AW-1:0];
    assign w_rd     = w_rd_f[AW-1:0];
    assign w_fmt    = decode_fmt(w_opcode);
    assign w_imm32  = $signed(imm_gen(i_instr, w_fmt.imm_type));
    assign w_imm    = XLEN'(w_imm32);

    // Only fields the format actually uses can make an RV32E instruction illegal.
    assign w_idx_bad = (w_fmt.use_rs1 && (int'(w_rs1_f) >= NUM_REGS)) ||
                       (w_fmt.use_rs2 && (int'(w_rs2_f) >= NUM_REGS)) ||
                       (w_fmt.use_rd  && (int'(w_rd_f)  >= NUM_REGS));
    assign w_illegal = !w_fmt.known || w_idx_bad;

    regfile #(
        .XLEN      (XLEN),
        .NUM_REGS  (NUM_REGS),
        .BYPASS_WB (BYPASS_WB)
    ) u_regfile (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_wren   (i_wb_wren),
        .i_waddr  (i_wb_rd_addr),
        .i_wdata  (i_wb_data),
        .i_raddr1 (w_rs1),
        .i_raddr2 (w_rs2),
        .o_rdata1 (w_rs1_data),
        .o_rdata2 (w_rs2_data)
    );

    // Load data is not available until after MEM, so a dependent instruction waits one cycle.
    assign w_hazard = HAZARD_EN && r_vld_p1 && (r_opcode_p1 == OP_LOAD) && (r_rd_p1 != '0) &&
                      ((w_fmt.use_rs1 && (w_rs1 == r_rd_p1)) ||
                       (w_fmt.use_rs2 && (w_rs2 == r_rd_p1)));

    assign w_adv      = !r_vld_p1 || i_ex_ready;
    assign o_id_ready = w_adv && !w_hazard;
    assign w_capture  = i_if_valid && o_id_ready;

    // ID/EX stage boundary
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld_p1      <= 1'b0;
            r_pc_p1       <= '0;
            r_rs1_data_p1 <= '0;
            r_rs2_data_p1 <= '0;
            r_imm_p1      <= '0;
            r_rd_p1       <= '0;
            r_opcode_p1   <= '0;
            r_funct3_p1   <= '0;
            r_funct7b5_p1 <= 1'b0;
            r_illegal_p1  <= 1'b0;
        end else if (i_flush) begin
            r_vld_p1 <= 1'b0;
        end else if (w_adv) begin
            r_vld_p1 <= w_capture;
            if (w_capture) begin
                r_pc_p1       <= i_pc;
                r_rs1_data_p1 <= w_rs1_data;
                r_rs2_data_p1 <= w_rs2_data;
                r_imm_p1      <= w_imm;
                r_rd_p1       <= w_rd;
                r_opcode_p1   <= w_opcode;
                r_funct3_p1   <= i_instr[14:12];
                r_funct7b5_p1 <= i_instr[30];
                r_illegal_p1  <= w_illegal;
            end
        end
    end

    assign o_ex_valid   = r_vld_p1;
    assign o_ex_pc      = r_pc_p1;
    assign o_rs1_data   = r_rs1_data_p1;
    assign o_rs2_data   = r_rs2_data_p1;
    assign o_imme_value = r_imm_p1;
    assign o_rd_addr    = r_rd_p1;
    assign o_opcode     = r_opcode_p1;
    assign o_funct3     = r_funct3_p1;
    assign o_funct7b5   = r_funct7b5_p1;
    assign o_illegal    = r_illegal_p1;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Scoreboard bench for decode_stage_pipe: directed instructions with hand-computed
// ID/EX contents, plus an RV32E instance for the register-index legality check.
module tb_decode_stage_pipe;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_if_valid = 1'b0;
    logic [31:0] i_instr = '0;
    logic [31:0] i_pc = '0;
    logic        i_flush = 1'b0;
    logic        i_wb_wren = 1'b0;
    logic [4:0]  i_wb_rd_addr = '0;
    logic [31:0] i_wb_data = '0;
    logic        i_ex_ready = 1'b1;

    logic        o_id_ready;
    logic        o_ex_valid;
    logic [31:0] o_ex_pc;
    logic [31:0] o_rs1_data;
    logic [31:0] o_rs2_data;
    logic [31:0] o_imme_value;
    logic [4:0]  o_rd_addr;
    logic [6:0]  o_opcode;
    logic [2:0]  o_funct3;
    logic        o_funct7b5;
    logic        o_illegal;

    logic        e_id_ready;
    logic        e_ex_valid;
    logic [31:0] e_ex_pc;
    logic [31:0] e_rs1_data;
    logic [31:0] e_rs2_data;
    logic [31:0] e_imme_value;
    logic [3:0]  e_rd_addr;
    logic [6:0]  e_opcode;
    logic [2:0]  e_funct3;
    logic        e_funct7b5;
    logic        e_illegal;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        ill;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;

    always #5 i_clk = ~i_clk;

    decode_stage_pipe #(.XLEN(32), .NUM_REGS(32)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_if_valid   (i_if_valid),
        .o_id_ready   (o_id_ready),
        .i_instr      (i_instr),
        .i_pc         (i_pc),
        .i_flush      (i_flush),
        .i_wb_wren    (i_wb_wren),
        .i_wb_rd_addr (i_wb_rd_addr),
        .i_wb_data    (i_wb_data),
        .i_ex_ready   (i_ex_ready),
        .o_ex_valid   (o_ex_valid),
        .o_ex_pc      (o_ex_pc),
        .o_rs1_data   (o_rs1_data),
        .o_rs2_data   (o_rs2_data),
        .o_imme_value (o_imme_value),
        .o_rd_addr    (o_rd_addr),
        .o_opcode     (o_opcode),
        .o_funct3     (o_funct3),
        .o_funct7b5   (o_funct7b5),
        .o_illegal    (o_illegal)
    );

    decode_stage_pipe #(.XLEN(32), .NUM_REGS(16)) dut_e (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_if_valid   (i_if_valid),
        .o_id_ready   (e_id_ready),
        .i_instr      (i_instr),
        .i_pc         (i_pc),
        .i_flush      (i_flush),
        .i_wb_wren    (i_wb_wren),
        .i_wb_rd_addr (i_wb_rd_addr[3:0]),
        .i_wb_data    (i_wb_data),
        .i_ex_ready   (i_ex_ready),
        .o_ex_valid   (e_ex_valid),
        .o_ex_pc      (e_ex_pc),
        .o_rs1_data   (e_rs1_data),
        .o_rs2_data   (e_rs2_data),
        .o_imme_value (e_imme_value),
        .o_rd_addr    (e_rd_addr),
        .o_opcode     (e_opcode),
        .o_funct3     (e_funct3),
        .o_funct7b5   (e_funct7b5),
        .o_illegal    (e_illegal)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ex_valid"}, 32'(o_ex_valid), 32'h0);
        chk({tag, "_pc"},       o_ex_pc, 32'h0);
        chk({tag, "_rs1"},      o_rs1_data, 32'h0);
        chk({tag, "_rs2"},      o_rs2_data, 32'h0);
        chk({tag, "_imm"},      o_imme_value, 32'h0);
        chk({tag, "_rd"},       32'(o_rd_addr), 32'h0);
        chk({tag, "_opcode"},   32'(o_opcode), 32'h0);
        chk({tag, "_funct3"},   32'(o_funct3), 32'h0);
        chk({tag, "_f7b5"},     32'(o_funct7b5), 32'h0);
        chk({tag, "_illegal"},  32'(o_illegal), 32'h0);
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [31:0] imm, input logic ill);
        exp_t e;
        e.pc  = pc;
        e.rs1 = rs1;
        e.rs2 = rs2;
        e.imm = imm;
        e.rd  = instr[11:7];
        e.op  = instr[6:0];
        e.f3  = instr[14:12];
        e.f7  = instr[30];
        e.ill = ill;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Present one instruction and wait (bounded) until ID accepts it.
    task automatic send(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [31:0] imm, input logic ill);
        bit done = 1'b0;
        i_if_valid = 1'b1;
        i_instr    = instr;
        i_pc       = pc;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge i_clk);
            if (o_id_ready && !i_flush) begin
                push(instr, pc, rs1, rs2, imm, ill);
                done = 1'b1;
            end
            step();
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: instr 0x%08h not accepted, required acceptance within 20 cycles", instr);
        end
        i_if_valid = 1'b0;
    endtask

    always @(negedge i_clk) begin
        if (i_rst_n && o_ex_valid && (i_ex_ready || i_flush)) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: pc 0x%08h presented, required none", o_ex_pc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("mon_pc",      o_ex_pc, e.pc);
                chk("mon_rs1",     o_rs1_data, e.rs1);
                chk("mon_rs2",     o_rs2_data, e.rs2);
                chk("mon_imm",     o_imme_value, e.imm);
                chk("mon_rd",      32'(o_rd_addr), 32'(e.rd));
                chk("mon_opcode",  32'(o_opcode), 32'(e.op));
                chk("mon_funct3",  32'(o_funct3), 32'(e.f3));
                chk("mon_f7b5",    32'(o_funct7b5), 32'(e.f7));
                chk("mon_illegal", 32'(o_illegal), 32'(e.ill));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on reset
        repeat (2) @(posedge i_clk);
        #1;
        chk_all_zero("por");
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("por_id_ready", 32'(o_id_ready), 32'h1);
        step();

        // Same-cycle write-back bypass: add x3,x2,x2 while x2 is written
        i_wb_wren = 1'b1; i_wb_rd_addr = 5'd2; i_wb_data = 32'h0041_0133;
        send(32'h0021_01B3, 32'h0000_0100, 32'h0041_0133, 32'h0041_0133, 32'h0, 1'b0);
        i_wb_wren = 1'b0;

        // x0 write dropped, also not forwarded; then stored x2 read back
        i_wb_wren = 1'b1; i_wb_rd_addr = 5'd0; i_wb_data = 32'hDEAD_BEEF;
        step();
        send(32'h0000_0033, 32'h0000_0104, 32'h0, 32'h0, 32'h0, 1'b0);
        i_wb_wren = 1'b0;
        send(32'h0001_0233, 32'h0000_0108, 32'h0041_0133, 32'h0, 32'h0, 1'b0);

        // Immediate formats back to back, plus an unknown opcode
        send(32'hFFF0_0093, 32'h0000_0200, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0);
        send(32'h0020_A423, 32'h0000_0204, 32'h0, 32'h0041_0133, 32'h0000_0008, 1'b0);
        send(32'hFE00_0EE3, 32'h0000_0208, 32'h0, 32'h0, 32'hFFFF_FFFC, 1'b0);
        send(32'h1234_52B7, 32'h0000_020C, 32'h0, 32'h0, 32'h1234_5000, 1'b0);
        send(32'h0000_007F, 32'h0000_0210, 32'h0, 32'h0, 32'h0, 1'b1);
        repeat (2) step();

        // Load-use: lw x5 then add x6,x5,x0 stalls one cycle
        send(32'h0000_A283, 32'h0000_0300, 32'h0, 32'h0, 32'h0, 1'b0);
        i_if_valid = 1'b1; i_instr = 32'h0002_8333; i_pc = 32'h0000_0304;
        @(negedge i_clk);
        chk("lu_stall_ready", 32'(o_id_ready), 32'h0);
        step();
        @(negedge i_clk);
        chk("lu_bubble_valid", 32'(o_ex_valid), 32'h0);
        chk("lu_resume_ready", 32'(o_id_ready), 32'h1);
        push(32'h0002_8333, 32'h0000_0304, 32'h0, 32'h0, 32'h0, 1'b0);
        step();
        i_if_valid = 1'b0;
        repeat (2) step();

        // EX back-pressure for 3 cycles, then flush
        send(32'h0050_0393, 32'h0000_0330, 32'h0, 32'h0, 32'h0000_0005, 1'b0);
        i_ex_ready = 1'b0;
        i_if_valid = 1'b1; i_instr = 32'h0110_00B3; i_pc = 32'h0000_0340;
        for (int c = 0; c < 3; c++) begin
            @(negedge i_clk);
            chk("bp_id_ready", 32'(o_id_ready), 32'h0);
            chk("bp_valid", 32'(o_ex_valid), 32'h1);
            chk("bp_pc_hold", o_ex_pc, 32'h0000_0330);
            chk("bp_imm_hold", o_imme_value, 32'h0000_0005);
            step();
        end
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        i_ex_ready = 1'b1;
        @(negedge i_clk);
        chk("flush_valid", 32'(o_ex_valid), 32'h0);
        chk("flush_ready", 32'(o_id_ready), 32'h1);
        push(32'h0110_00B3, 32'h0000_0340, 32'h0, 32'h0, 32'h0, 1'b0);
        step();
        i_if_valid = 1'b0;
        @(negedge i_clk);
        chk("rv32e_illegal", 32'(e_illegal), 32'h1);
        chk("rv32e_rd", 32'(e_rd_addr), 32'h1);
        step();

        // Reset in the middle of a held instruction
        send(32'h0051_0393, 32'h0000_0400, 32'h0041_0133, 32'h0, 32'h0000_0005, 1'b0);
        i_ex_ready = 1'b0;
        @(negedge i_clk);
        chk("pre_rst_valid", 32'(o_ex_valid), 32'h1);
        chk("pre_rst_rs1", o_rs1_data, 32'h0041_0133);
        @(posedge i_clk);
        #3;
        i_rst_n = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        sb_q.delete();
        step();
        i_rst_n = 1'b1;
        i_ex_ready = 1'b1;
        @(negedge i_clk);
        chk("rst_release_ready", 32'(o_id_ready), 32'h1);
        step();
        send(32'h0001_0233, 32'h0000_0500, 32'h0, 32'h0, 32'h0, 1'b0);

        repeat (3) step();
        chk("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
